// File: rtl/ifetch.sv
// ifetch: single-issue instruction fetch front end.
//
// Issues one 16-bit byte address per cycle to a memory that returns a 24-bit
// window (three consecutive bytes, lowest address in [7:0]) one cycle later.
// The returned window is handed to the decoder unchanged. The decoder
// consumes 1..3 bytes per accept, and the next address is computed
// combinationally so that back-to-back instructions stream at one per cycle.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   reset_n      synchronous active-low reset
//   iread_addr   read address to memory (combinational)
//   iread_data   window returned for the previous cycle's address
//   iread_valid  iread_data valid this cycle
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  restart address, used only while redirect=1
//   halt         freeze fetch while high
//   insn_data    instruction window to the decoder
//   insn_pc      address of insn_data[7:0]
//   insn_valid   insn_data / insn_pc valid
//   insn_ready   decoder accepts the window this cycle
//   insn_len     bytes consumed on accept (0 is treated as 1)
//   fetch_count  saturating count of accepted instructions

module ifetch #(
    parameter logic [15:0] ROMBASE = 16'h4000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] iread_addr,
    input  logic [23:0] iread_data,
    input  logic        iread_valid,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic [23:0] insn_data,
    output logic [15:0] insn_pc,
    output logic        insn_valid,
    input  logic        insn_ready,
    input  logic [1:0]  insn_len,
    output logic [15:0] fetch_count
);

    // START: reset/redirect address issued, nothing returned yet.
    // RUN:   a read is in flight and its data may be presented.
    // HALTED: frozen; the held address stays in flight.
    localparam logic [1:0] START  = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] req_pc_q;
    logic [15:0] fetch_count_q;
    logic [15:0] eff_len;
    logic        accept;

    always_comb begin
        eff_len = (insn_len == 2'd0) ? 16'd1 : {14'd0, insn_len};
    end

    // Gated by reset_n so a window in flight when reset asserts is dropped
    // in the reset cycle itself.
    always_comb begin
        insn_valid = reset_n & (state_q == RUN) & iread_valid & ~redirect & ~halt;
        accept     = insn_valid & insn_ready;
    end

    always_comb begin
        insn_data   = iread_data;
        insn_pc     = req_pc_q;
        fetch_count = fetch_count_q;
    end

    // accept already implies !halt, so a halted cycle simply re-issues req_pc.
    // Re-issuing req_pc on a stall makes memory return the same window again.
    always_comb begin
        if (!reset_n) begin
            iread_addr = ROMBASE;
        end else if (redirect) begin
            iread_addr = redirect_pc;
        end else if (accept) begin
            iread_addr = req_pc_q + eff_len;
        end else begin
            iread_addr = req_pc_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            START: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (redirect) begin
                    // Redirect address was just issued; its data is not back yet.
                    state_d = START;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A redirect stays in RUN: the new address is in flight and
                // its data is presented next cycle with no extra bubble.
                if (halt) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                // The held address is re-issued every halted cycle, so data
                // for it is already back when RUN is entered.
                if (!halt) begin
                    state_d = RUN;
                end
            end
            default: state_d = START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= START;
            req_pc_q      <= ROMBASE;
            fetch_count_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= iread_addr;
            if (accept && (fetch_count_q != 16'hFFFF)) begin
                fetch_count_q <= fetch_count_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Testbench for ifetch: directed scenarios followed by randomized traffic,
// all compared against a transaction-level model of the fetch stream.

module tb_ifetch;

    localparam logic [15:0] ROMBASE = 16'h4000;

    logic        clk;
    logic        reset_n;
    logic [15:0] iread_addr;
    logic [23:0] iread_data;
    logic        iread_valid;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic [23:0] insn_data;
    logic [15:0] insn_pc;
    logic        insn_valid;
    logic        insn_ready;
    logic [1:0]  insn_len;
    logic [15:0] fetch_count;

    ifetch #(.ROMBASE(ROMBASE)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .iread_addr (iread_addr),
        .iread_data (iread_data),
        .iread_valid(iread_valid),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .insn_data  (insn_data),
        .insn_pc    (insn_pc),
        .insn_valid (insn_valid),
        .insn_ready (insn_ready),
        .insn_len   (insn_len),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [65536];

    function automatic logic [23:0] window(input logic [15:0] a);
        logic [15:0] a1, a2;
        a1 = a + 16'd1;
        a2 = a + 16'd2;
        return {mem[a2], mem[a1], mem[a]};
    endfunction

    // Synchronous memory: data for this cycle's address appears next cycle.
    always @(posedge clk) iread_data <= window(iread_addr);

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: m_pc is the address whose window comes back next; m_live says
    // the fetcher is streaming; m_starting says the first window after reset
    // or a start-time redirect is still on its way.
    logic [15:0] m_pc = ROMBASE;
    logic [15:0] m_cnt = 16'd0;
    bit          m_live = 1'b0;
    bit          m_starting = 1'b1;
    bit          m_cnt_known = 1'b0;

    task automatic cycle(input bit rn, input bit rd, input logic [15:0] rpc, input bit hl,
                         input bit iv, input bit rdy, input logic [1:0] ln);
        bit          exp_valid, acc;
        logic [15:0] len, exp_addr;
        @(negedge clk);
        reset_n     = rn;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hl;
        iread_valid = iv;
        insn_ready  = rdy;
        insn_len    = ln;
        #1;
        len       = (ln == 2'd0) ? 16'd1 : 16'(ln);
        exp_valid = rn && m_live && iv && !rd && !hl;
        acc       = exp_valid && rdy;
        if (!rn)       exp_addr = ROMBASE;
        else if (rd)   exp_addr = rpc;
        else if (acc)  exp_addr = m_pc + len;
        else           exp_addr = m_pc;

        check_eq("insn_valid", 32'(insn_valid), 32'(exp_valid));
        check_eq("iread_addr", 32'(iread_addr), 32'(exp_addr));
        if (exp_valid) begin
            check_eq("insn_pc", 32'(insn_pc), 32'(m_pc));
            check_eq("insn_data", 32'(insn_data), 32'(window(m_pc)));
        end
        if (rn && m_cnt_known) check_eq("fetch_count", 32'(fetch_count), 32'(m_cnt));

        if (!rn) begin
            m_pc        = ROMBASE;
            m_cnt       = 16'd0;
            m_cnt_known = 1'b1;
            m_starting  = 1'b1;
            m_live      = 1'b0;
        end else begin
            m_starting = m_starting && rd && !hl;
            m_live     = !hl && !m_starting;
            m_pc       = exp_addr;
            if (acc && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h4000] = 8'h11;
        mem[16'h4001] = 8'h22;
        mem[16'h4002] = 8'h33;
        mem[16'h4003] = 8'h44;

        // Reset release and first windows
        cycle(0, 0, 0, 0, 1, 1, 1);
        cycle(0, 0, 0, 0, 1, 1, 1);
        cycle(1, 0, 0, 0, 1, 1, 1);
        check_eq("r36_start_invalid", 32'(insn_valid), 0);
        cycle(1, 0, 0, 0, 1, 1, 1);
        check_eq("r36_pc0", 32'(insn_pc), 32'h4000);
        check_eq("r36_data0", 32'(insn_data), 32'h332211);
        cycle(1, 0, 0, 0, 1, 1, 1);
        check_eq("r36_pc1", 32'(insn_pc), 32'h4001);
        check_eq("r36_data1", 32'(insn_data), 32'h443322);

        // Lengths 3,2,1 from ROMBASE
        cycle(0, 0, 0, 0, 1, 0, 1);
        cycle(1, 0, 0, 0, 1, 1, 3);
        cycle(1, 0, 0, 0, 1, 1, 3);
        check_eq("r37_pc0", 32'(insn_pc), 32'h4000);
        cycle(1, 0, 0, 0, 1, 1, 2);
        check_eq("r37_pc1", 32'(insn_pc), 32'h4003);
        cycle(1, 0, 0, 0, 1, 1, 1);
        check_eq("r37_pc2", 32'(insn_pc), 32'h4005);
        cycle(1, 0, 0, 0, 1, 0, 1);
        check_eq("r37_pc3", 32'(insn_pc), 32'h4006);
        check_eq("r37_count", 32'(fetch_count), 3);

        // Redirect beats a same-cycle accept
        cycle(1, 1, 16'h4100, 0, 1, 1, 1);
        check_eq("r39_squash", 32'(insn_valid), 0);
        cycle(1, 0, 0, 0, 1, 0, 1);
        check_eq("r39_pc", 32'(insn_pc), 32'h4100);
        check_eq("r39_count", 32'(fetch_count), 3);

        // Address wrap
        cycle(1, 1, 16'hFFFE, 0, 1, 0, 1);
        cycle(1, 0, 0, 0, 1, 1, 3);
        check_eq("r40_pc", 32'(insn_pc), 32'hFFFE);
        check_eq("r40_addr", 32'(iread_addr), 32'h0001);
        cycle(1, 0, 0, 0, 1, 0, 1);
        check_eq("r40_next_pc", 32'(insn_pc), 32'h0001);

        // Halt with iread_valid toggling
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 1, (i % 2 == 0), 1, 1);
            check_eq("r41_halt_invalid", 32'(insn_valid), 0);
            check_eq("r41_halt_addr", 32'(iread_addr), 32'h0001);
        end
        cycle(1, 0, 0, 0, 1, 0, 1);
        cycle(1, 0, 0, 0, 1, 0, 1);
        check_eq("r41_resume_valid", 32'(insn_valid), 1);
        check_eq("r41_resume_pc", 32'(insn_pc), 32'h0001);

        // Decoder stall for four cycles
        cycle(1, 1, 16'h4010, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 0, 1, 0, 2);
            check_eq("r38_stall_pc", 32'(insn_pc), 32'h4010);
            check_eq("r38_stall_data", 32'(insn_data), 32'(window(16'h4010)));
            check_eq("r38_stall_count", 32'(fetch_count), 4);
        end
        cycle(1, 0, 0, 0, 1, 1, 2);
        cycle(1, 0, 0, 0, 1, 0, 1);
        check_eq("r38_next_pc", 32'(insn_pc), 32'h4012);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(199) != 0),
                  ($urandom_range(15) == 0),
                  16'($urandom),
                  ($urandom_range(9) == 0),
                  ($urandom_range(3) != 0),
                  ($urandom_range(3) != 0),
                  2'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
